// File: rtl/ovdp_audio_pkg.sv
// ovdp_audio_pkg -- shared audio types and constants for the OVDP output path.
//   DEF_SAMPLE_W   : default bits per channel
//   I2S_FRAME_BITS : bits in one stereo frame (left + right)
//   stereo_frame_t : packed stereo frame, left in the upper half
package ovdp_audio_pkg;

  localparam int DEF_SAMPLE_W   = 16;
  localparam int I2S_FRAME_BITS = 2 * DEF_SAMPLE_W;

  typedef struct packed {
    logic signed [DEF_SAMPLE_W-1:0] left;
    logic signed [DEF_SAMPLE_W-1:0] right;
  } stereo_frame_t;

endpackage

// File: rtl/ovdp_sample_fifo.sv
// ovdp_sample_fifo -- synchronous show-ahead FIFO for stereo PCM frames.
// Ports:
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   push_i / wdata_i    : write request and data (ignored while full)
//   pop_i               : read request (ignored while empty)
//   rdata_o             : head-of-queue entry, valid whenever !empty_o
//   full_o / empty_o    : registered occupancy flags
module ovdp_sample_fifo
  import ovdp_audio_pkg::*;
#(
  parameter int WIDTH = I2S_FRAME_BITS,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
    // Flags are registered from the next occupancy so they are exact
    // in the cycle right after the changing edge.
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/ovdp_i2s_tx.sv
// ovdp_i2s_tx -- OVDP audio output stage: Avalon-ST stereo frame sink,
// frame FIFO and Philips I2S serialiser (BCLK, LRCLK, SDATA).
// Ports:
//   clk_clk, reset_reset_n : system clock, asynchronous active-low reset
//   sink_valid/sink_data   : Avalon-ST frame input ([2W-1:W] left, [W-1:0] right)
//   sink_ready             : FIFO not full (registered)
//   i2s_bclk, i2s_lrclk    : bit clock, word select (0 = left)
//   i2s_sdata              : serial data, MSB first, one BCLK after LRCLK
//   underrun               : one-clk pulse when a frame starts with the FIFO empty
// Build option:
//   OVDP_I2S_HOLD_LAST_EN  : on underrun repeat the last frame popped instead
//                            of sending silence.
module ovdp_i2s_tx
  import ovdp_audio_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter int SAMPLE_W   = DEF_SAMPLE_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  sink_valid,
  input  logic [2*SAMPLE_W-1:0] sink_data,
  output logic                  sink_ready,
  output logic                  i2s_bclk,
  output logic                  i2s_lrclk,
  output logic                  i2s_sdata,
  output logic                  underrun
);

  localparam int FRAME_W = 2 * SAMPLE_W;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] RIGHT_1ST = BIT_W'(SAMPLE_W);

  logic [DIV_W-1:0]   div_q, div_d;
  logic               bclk_q, bclk_d;
  logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
  logic               lrclk_q, lrclk_d;
  logic               sdata_q, sdata_d;
  logic               underrun_q, underrun_d;
  logic [FRAME_W-1:0] shift_q, shift_d;

  logic [FRAME_W-1:0] fifo_rdata;
  logic               fifo_full, fifo_empty;
  logic               push, pop;
  logic               div_wrap, bclk_fall, fetch;
  logic [FRAME_W-1:0] idle_frame, load_frame;

  assign div_wrap  = (div_q == DIV_LAST);
  assign bclk_fall = div_wrap && bclk_q;
  // The falling edge that moves bitcnt 0 -> 1 starts a new frame on SDATA.
  assign fetch     = bclk_fall && (bitcnt_q == '0);
  assign push      = sink_valid && !fifo_full;
  assign pop       = fetch && !fifo_empty;

  ovdp_sample_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_clk),
    .rst_ni  (reset_reset_n),
    .push_i  (push),
    .wdata_i (sink_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef OVDP_I2S_HOLD_LAST_EN
  logic [FRAME_W-1:0] hold_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      hold_q <= '0;
    end else if (pop) begin
      hold_q <= fifo_rdata;
    end
  end

  assign idle_frame = hold_q;
`else
  assign idle_frame = '0;
`endif

  assign load_frame = fifo_empty ? idle_frame : fifo_rdata;

  always_comb begin
    div_d      = div_wrap ? '0 : div_q + 1'b1;
    bclk_d     = bclk_q ^ div_wrap;
    bitcnt_d   = bitcnt_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    shift_d    = shift_q;
    underrun_d = 1'b0;
    if (bclk_fall) begin
      bitcnt_d = (bitcnt_q == BIT_LAST) ? '0 : bitcnt_q + 1'b1;
      lrclk_d  = (bitcnt_d >= RIGHT_1ST);
      if (fetch) begin
        // MSB goes straight to the pin; the rest waits in the shifter.
        sdata_d    = load_frame[FRAME_W-1];
        shift_d    = {load_frame[FRAME_W-2:0], 1'b0};
        underrun_d = fifo_empty;
      end else begin
        sdata_d = shift_q[FRAME_W-1];
        shift_d = {shift_q[FRAME_W-2:0], 1'b0};
      end
    end
  end

  // bitcnt starts at its last value so the first falling edge opens a
  // frame at bitcnt 0 with LRCLK dropping to the left channel.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      div_q      <= '0;
      bclk_q     <= 1'b0;
      bitcnt_q   <= BIT_LAST;
      lrclk_q    <= 1'b1;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
      shift_q    <= '0;
    end else begin
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      bitcnt_q   <= bitcnt_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      shift_q    <= shift_d;
    end
  end

  assign sink_ready = !fifo_full;
  assign i2s_bclk   = bclk_q;
  assign i2s_lrclk  = lrclk_q;
  assign i2s_sdata  = sdata_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_ovdp_i2s_tx.sv
// tb_ovdp_i2s_tx -- directed bench for ovdp_i2s_tx (CLK_DIV=2, SAMPLE_W=16,
// FIFO_DEPTH=8). Frames are recovered from the I2S pins by sampling SDATA on
// BCLK rising edges, starting from an LRCLK falling edge.
module tb_ovdp_i2s_tx;
  import ovdp_audio_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int SW      = 16;
  localparam int DEPTH   = 8;
`ifdef OVDP_I2S_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk_clk = 1'b0;
  logic          reset_reset_n = 1'b0;
  logic          sink_valid = 1'b0;
  logic [2*SW-1:0] sink_data = '0;
  logic          sink_ready;
  logic          i2s_bclk, i2s_lrclk, i2s_sdata, underrun;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] rx_f [16];
  int          rx_u [16];
  bit          rx_ok;
  int          last_wait;

  ovdp_i2s_tx #(
    .CLK_DIV    (CLK_DIV),
    .SAMPLE_W   (SW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .sink_valid    (sink_valid),
    .sink_data     (sink_data),
    .sink_ready    (sink_ready),
    .i2s_bclk      (i2s_bclk),
    .i2s_lrclk     (i2s_lrclk),
    .i2s_sdata     (i2s_sdata),
    .underrun      (underrun)
  );

  always #5 clk_clk = ~clk_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_lr_fall(output bit ok);
    int n;
    logic pb;
    n  = 0;
    ok = 1'b0;
    pb = i2s_lrclk;
    while (n < 400) begin
      @(negedge clk_clk);
      n++;
      if (pb === 1'b1 && i2s_lrclk === 1'b0) begin
        ok = 1'b1;
        break;
      end
      pb = i2s_lrclk;
    end
  endtask

  task automatic wait_lr_rise(output bit ok);
    int n;
    logic pb;
    n  = 0;
    ok = 1'b0;
    pb = i2s_lrclk;
    while (n < 400) begin
      @(negedge clk_clk);
      n++;
      if (pb === 1'b0 && i2s_lrclk === 1'b1) begin
        ok = 1'b1;
        break;
      end
      pb = i2s_lrclk;
    end
  endtask

  // Leaves sink_valid high so consecutive calls push on consecutive clks.
  task automatic push_frame(input logic [31:0] d, output bit ok);
    int n;
    sink_valid = 1'b1;
    sink_data  = d;
    n = 0;
    while (sink_ready !== 1'b1 && n < 400) begin
      @(negedge clk_clk);
      n++;
    end
    ok = (sink_ready === 1'b1);
    last_wait = n;
    @(negedge clk_clk);
  endtask

  // Collect nf frames; rx_u[k] counts underrun pulses at frame k's fetch.
  task automatic recv(input int nf);
    int n, bits;
    bit skipped, got;
    logic pb;
    rx_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_f[i] = '0;
      rx_u[i] = 0;
    end
    wait_lr_fall(got);
    if (!got) begin
      rx_ok = 1'b0;
      return;
    end
    bits    = 0;
    skipped = 1'b0;
    n       = 0;
    pb      = i2s_bclk;
    while (bits < nf * 32) begin
      @(negedge clk_clk);
      n++;
      if (underrun === 1'b1) rx_u[bits / 32]++;
      if (pb === 1'b0 && i2s_bclk === 1'b1) begin
        if (skipped) begin
          rx_f[bits / 32][31 - (bits % 32)] = i2s_sdata;
          bits++;
        end else begin
          skipped = 1'b1;
        end
      end
      pb = i2s_bclk;
      if (n > nf * 128 + 64) begin
        rx_ok = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    sink_valid    = 1'b0;
    reset_reset_n = 1'b0;
    repeat (3) @(negedge clk_clk);
    n_cmp++; if (i2s_bclk !== 1'b0)   begin n_fail++; $display("FAIL rst_bclk: got %b want 0", i2s_bclk); end
    n_cmp++; if (i2s_lrclk !== 1'b1)  begin n_fail++; $display("FAIL rst_lrclk: got %b want 1", i2s_lrclk); end
    n_cmp++; if (i2s_sdata !== 1'b0)  begin n_fail++; $display("FAIL rst_sdata: got %b want 0", i2s_sdata); end
    n_cmp++; if (underrun !== 1'b0)   begin n_fail++; $display("FAIL rst_underrun: got %b want 0", underrun); end
    n_cmp++; if (sink_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", sink_ready); end
  endtask

  task automatic test_idle();
    int n;
    logic pb;
    bit ok;
    reset_reset_n = 1'b1;
    n = 0;
    while (i2s_bclk !== 1'b1 && n < 50) begin
      @(negedge clk_clk);
      n++;
    end
    n_cmp++; if (n !== CLK_DIV) begin n_fail++; $display("FAIL idle_first_rise: got %0d clk want %0d", n, CLK_DIV); end
    n  = 0;
    pb = i2s_bclk;
    while (n < 50) begin
      @(negedge clk_clk);
      n++;
      if (pb === 1'b0 && i2s_bclk === 1'b1) break;
      pb = i2s_bclk;
    end
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL idle_bclk_period: got %0d want 4", n); end
    wait_lr_fall(ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL idle_lr_fall: got timeout want edge"); end
    n = 0;
    while (i2s_lrclk !== 1'b1 && n < 200) begin
      @(negedge clk_clk);
      n++;
    end
    n_cmp++; if (n !== 64) begin n_fail++; $display("FAIL idle_lr_low: got %0d want 64", n); end
    n = 0;
    while (i2s_lrclk !== 1'b0 && n < 200) begin
      @(negedge clk_clk);
      n++;
    end
    n_cmp++; if (n !== 64) begin n_fail++; $display("FAIL idle_lr_high: got %0d want 64", n); end
    recv(2);
    n_cmp++; if (rx_ok !== 1'b1) begin n_fail++; $display("FAIL idle_rx: got timeout want frames"); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (rx_f[i] !== 32'h0) begin n_fail++; $display("FAIL idle_frame%0d: got %h want 00000000", i, rx_f[i]); end
      n_cmp++; if (rx_u[i] !== 1) begin n_fail++; $display("FAIL idle_underrun%0d: got %0d want 1", i, rx_u[i]); end
    end
  endtask

  task automatic test_pattern();
    bit ok;
    stereo_frame_t fr;
    logic [31:0] idle;
    fr.left  = 16'hA5A5;
    fr.right = 16'h0F0F;
    idle = HOLD ? 32'hA5A5_0F0F : 32'h0;
    wait_lr_rise(ok);
    push_frame(fr, ok);
    sink_valid = 1'b0;
    recv(2);
    n_cmp++; if (rx_ok !== 1'b1) begin n_fail++; $display("FAIL pat_rx: got timeout want frames"); end
    n_cmp++; if (rx_f[0][31:16] !== 16'b1010010110100101) begin n_fail++; $display("FAIL pat_left: got %b want 1010010110100101", rx_f[0][31:16]); end
    n_cmp++; if (rx_f[0][15:0] !== 16'b0000111100001111) begin n_fail++; $display("FAIL pat_right: got %b want 0000111100001111", rx_f[0][15:0]); end
    n_cmp++; if (rx_u[0] !== 0) begin n_fail++; $display("FAIL pat_underrun0: got %0d want 0", rx_u[0]); end
    n_cmp++; if (rx_f[1] !== idle) begin n_fail++; $display("FAIL pat_idle: got %h want %h", rx_f[1], idle); end
    n_cmp++; if (rx_u[1] !== 1) begin n_fail++; $display("FAIL pat_underrun1: got %0d want 1", rx_u[1]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] fv [9];
    logic [31:0] exp;
    bit ok, ok2;
    for (int i = 0; i < 9; i++) fv[i] = 32'h0F0F_1234 + 32'h1111_1111 * i;
    fork
      begin
        wait_lr_rise(ok2);
        recv(10);
      end
      begin
        wait_lr_rise(ok);
        for (int i = 0; i < 7; i++) push_frame(fv[i], ok);
        n_cmp++; if (sink_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready7: got %b want 1", sink_ready); end
        push_frame(fv[7], ok);
        n_cmp++; if (sink_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready8: got %b want 0", sink_ready); end
        sink_data = fv[8];
        @(negedge clk_clk);
        n_cmp++; if (sink_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_held: got %b want 0", sink_ready); end
        push_frame(fv[8], ok);
        n_cmp++; if (ok !== 1'b1 || last_wait < 8) begin n_fail++; $display("FAIL b2b_ninth: got ok=%b wait=%0d want ok=1 wait>=8", ok, last_wait); end
        n_cmp++; if (sink_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_refull: got %b want 0", sink_ready); end
        sink_valid = 1'b0;
      end
    join
    n_cmp++; if (rx_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_rx: got timeout want frames"); end
    for (int i = 0; i < 10; i++) begin
      exp = (i < 9) ? fv[i] : (HOLD ? fv[8] : 32'h0);
      n_cmp++; if (rx_f[i] !== exp) begin n_fail++; $display("FAIL b2b_frame%0d: got %h want %h", i, rx_f[i], exp); end
      n_cmp++; if (rx_u[i] !== ((i < 9) ? 0 : 1)) begin n_fail++; $display("FAIL b2b_underrun%0d: got %0d want %0d", i, rx_u[i], (i < 9) ? 0 : 1); end
    end
  endtask

  task automatic test_push_pop_same_clk();
    logic [31:0] ev [9];
    logic [31:0] exp;
    bit ok, ok2;
    for (int i = 0; i < 9; i++) ev[i] = 32'hC000_0001 + 32'h0102_0304 * i;
    fork
      begin
        wait_lr_rise(ok2);
        recv(10);
      end
      begin
        wait_lr_rise(ok);
        for (int i = 0; i < 4; i++) push_frame(ev[i], ok);
        sink_valid = 1'b0;
        wait_lr_fall(ok);
        repeat (3) @(negedge clk_clk);
        // Next posedge is the fetch edge: push lands on the same clk as the pop.
        push_frame(ev[4], ok);
        for (int i = 5; i < 8; i++) push_frame(ev[i], ok);
        n_cmp++; if (sink_ready !== 1'b1) begin n_fail++; $display("FAIL pp_ready7: got %b want 1", sink_ready); end
        push_frame(ev[8], ok);
        n_cmp++; if (sink_ready !== 1'b0) begin n_fail++; $display("FAIL pp_ready8: got %b want 0", sink_ready); end
        sink_valid = 1'b0;
      end
    join
    n_cmp++; if (rx_ok !== 1'b1) begin n_fail++; $display("FAIL pp_rx: got timeout want frames"); end
    for (int i = 0; i < 10; i++) begin
      exp = (i < 9) ? ev[i] : (HOLD ? ev[8] : 32'h0);
      n_cmp++; if (rx_f[i] !== exp) begin n_fail++; $display("FAIL pp_frame%0d: got %h want %h", i, rx_f[i], exp); end
    end
  endtask

  task automatic test_underrun_frame();
    bit ok;
    logic [31:0] idle;
    idle = HOLD ? 32'h7FFF_8000 : 32'h0;
    wait_lr_rise(ok);
    push_frame(32'h7FFF_8000, ok);
    sink_valid = 1'b0;
    recv(3);
    n_cmp++; if (rx_ok !== 1'b1) begin n_fail++; $display("FAIL ur_rx: got timeout want frames"); end
    n_cmp++; if (rx_f[0] !== 32'h7FFF_8000) begin n_fail++; $display("FAIL ur_frame0: got %h want 7fff8000", rx_f[0]); end
    n_cmp++; if (rx_u[0] !== 0) begin n_fail++; $display("FAIL ur_pulse0: got %0d want 0", rx_u[0]); end
    for (int i = 1; i < 3; i++) begin
      n_cmp++; if (rx_f[i] !== idle) begin n_fail++; $display("FAIL ur_frame%0d: got %h want %h", i, rx_f[i], idle); end
      n_cmp++; if (rx_u[i] !== 1) begin n_fail++; $display("FAIL ur_pulse%0d: got %0d want 1", i, rx_u[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    wait_lr_fall(ok);
    repeat (8) @(negedge clk_clk);
    for (int i = 0; i < 5; i++) push_frame(32'h5A5A_0000 + i, ok);
    sink_valid = 1'b0;
    // Land mid-bitcnt 10 with BCLK high and LRCLK low.
    repeat (29) @(negedge clk_clk);
    n_cmp++; if (i2s_bclk !== 1'b1 || i2s_lrclk !== 1'b0) begin n_fail++; $display("FAIL mid_pre: got bclk=%b lr=%b want 1 0", i2s_bclk, i2s_lrclk); end
    reset_reset_n = 1'b0;
    #1;
    n_cmp++; if (i2s_bclk !== 1'b0)   begin n_fail++; $display("FAIL mid_bclk: got %b want 0", i2s_bclk); end
    n_cmp++; if (i2s_lrclk !== 1'b1)  begin n_fail++; $display("FAIL mid_lrclk: got %b want 1", i2s_lrclk); end
    n_cmp++; if (i2s_sdata !== 1'b0)  begin n_fail++; $display("FAIL mid_sdata: got %b want 0", i2s_sdata); end
    n_cmp++; if (underrun !== 1'b0)   begin n_fail++; $display("FAIL mid_underrun: got %b want 0", underrun); end
    n_cmp++; if (sink_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", sink_ready); end
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    recv(1);
    n_cmp++; if (rx_ok !== 1'b1) begin n_fail++; $display("FAIL mid_rx: got timeout want frame"); end
    n_cmp++; if (rx_f[0] !== 32'h0) begin n_fail++; $display("FAIL mid_frame: got %h want 00000000", rx_f[0]); end
    n_cmp++; if (rx_u[0] !== 1) begin n_fail++; $display("FAIL mid_underrun_pulse: got %0d want 1", rx_u[0]); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_pattern();
    test_back_to_back();
    test_push_pop_same_clk();
    test_underrun_frame();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
